stage_threshold_acc: RTL

- Upstream neighbour of the early-exit stage that yields on the first 0 or on eot.
- Consumes per-window feature responses as a two-level queue: eot[0] marks the last feature of a stage, eot[1] the last stage of the cascade.
- Accumulates each stage's responses, compares the stage sum against a per-stage threshold taken from a second stream, and emits one [u1] pass bit per stage.
- The output eot is set on the cascade's last stage, which is exactly the format the downstream early-exit block consumes.

---
 rtl/stage_threshold_acc_pkg.sv | 28 ++
 rtl/stage_threshold_acc_if.sv | 13 +
 rtl/stage_threshold_acc_sat_add.sv | 27 ++
 rtl/stage_threshold_acc.sv | 102 ++++++++++
 4 files changed

// File: rtl/stage_threshold_acc_pkg.sv
// rtl/stage_threshold_acc_pkg.sv - shared types, default widths and sign-extension helper
package stage_threshold_acc_pkg;

  localparam int DIN_W_DEF = 16;
  localparam int ACC_W_DEF = 24;

  typedef struct packed {
    logic [1:0]           eot;
    logic [DIN_W_DEF-1:0] data;
  } din_t;

  typedef struct packed {
    logic [0:0] eot;
    logic [0:0] data;
  } dout_t;

  // Output register occupancy; EMPTY/FULL is exactly dout.valid.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Sign-extends the low 'width' bits of raw to 64 bits; callers truncate to their accumulator width.
  function automatic logic signed [63:0] sext_acc(input logic [63:0] raw, input int width);
    return $signed(raw << (64 - width)) >>> (64 - width);
  endfunction

endpackage

// File: rtl/stage_threshold_acc_if.sv
// rtl/stage_threshold_acc_if.sv - valid/ready data-transfer interface (dti) with producer/consumer views
interface dti #(
  parameter int W = 8
);

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);

endinterface

// File: rtl/stage_threshold_acc_sat_add.sv
// rtl/stage_threshold_acc_sat_add.sv - combinational W-bit signed adder
// Saturates when STAGE_THRESHOLD_ACC_SAT_EN is defined, wraps otherwise.
module sat_add #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

`ifdef STAGE_THRESHOLD_ACC_SAT_EN
  logic [W:0] wide;

  // Overflow shows as the carry-out sign disagreeing with the result sign.
  always_comb begin
    wide = {a[W-1], a} + {b[W-1], b};
    if (wide[W] != wide[W-1]) begin
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum = wide[W-1:0];
    end
  end
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/stage_threshold_acc.sv
// rtl/stage_threshold_acc.sv - per-stage feature accumulator with threshold join, one pass bit per stage
// Optional saturating arithmetic: STAGE_THRESHOLD_ACC_SAT_EN.
module stage_threshold_acc
  import stage_threshold_acc_pkg::*;
#(
  parameter int DIN_W = DIN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic  clk,
  input  logic  rst,
  dti.consumer  din,
  dti.consumer  thr,
  dti.producer  dout
);

  logic [DIN_W-1:0]        din_data;
  logic [1:0]              din_eot;
  logic signed [ACC_W-1:0] din_sext;
  logic signed [ACC_W-1:0] thr_val;
  logic signed [ACC_W-1:0] sum_n;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  out_state_t              state;
  out_state_t              state_nxt;
  logic                    out_data;
  logic                    out_data_nxt;
  logic                    out_eot;
  logic                    out_eot_nxt;

  logic  out_valid;
  logic  can_load;
  logic  is_last;
  logic  fire;
  logic  acc_take;
  logic  out_take;
  dout_t out_word;

  assign din_data = din.data[DIN_W-1:0];
  assign din_eot  = din.data[DIN_W +: 2];
  assign din_sext = ACC_W'(sext_acc(64'(din_data), DIN_W));
  assign thr_val  = thr.data;

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (din_sext),
    .sum (sum_n)
  );

  assign out_valid = (state == OUT_FULL);
  assign can_load  = !out_valid || dout.ready;
  assign is_last   = din_eot[0];
  assign fire      = din.valid && is_last && thr.valid && can_load;
  assign acc_take  = din.valid && !is_last;
  assign out_take  = out_valid && dout.ready;

  // Non-last items never wait; the last item is a join with thr and the output slot.
  assign din.ready = rst && (!is_last || fire);
  assign thr.ready = rst && fire;

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    out_data_nxt = out_data;
    out_eot_nxt  = out_eot;
    if (fire) begin
      acc_nxt      = '0;
      out_data_nxt = (sum_n >= thr_val);
      out_eot_nxt  = din_eot[1];
      state_nxt    = OUT_FULL;
    end else begin
      if (acc_take) begin
        acc_nxt = sum_n;
      end
      if (out_take) begin
        state_nxt = OUT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= OUT_EMPTY;
      acc      <= '0;
      out_data <= 1'b0;
      out_eot  <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      out_data <= out_data_nxt;
      out_eot  <= out_eot_nxt;
    end
  end

  assign out_word   = '{eot: out_eot, data: out_data};
  assign dout.valid = out_valid;
  assign dout.data  = out_word;

  // A cascade-last marker on a non-stage-last item has no meaning.
  assert property (@(posedge clk) disable iff (!rst) din.valid |-> !(din_eot[1] && !din_eot[0]));

endmodule
